// File: rtl/enemy_wave_if.sv
// Handshake bundle between the game logic and the enemy wave controller:
// frame/hit/start strobes in, formation position and status out.
interface enemy_wave_if;
   logic        startOfFrame;
   logic        startGame;
   logic        hitValid;
   logic [2:0]  hitIndex;
   logic [10:0] formationX;
   logic [10:0] formationY;
   logic [7:0]  aliveMask;
   logic [3:0]  waveNumber;
   logic        waveCleared;
   logic        reachedBottom;

   modport master (
      output startOfFrame, startGame, hitValid, hitIndex,
      input  formationX, formationY, aliveMask, waveNumber, waveCleared, reachedBottom
   );

   modport slave (
      input  startOfFrame, startGame, hitValid, hitIndex,
      output formationX, formationY, aliveMask, waveNumber, waveCleared, reachedBottom
   );
endinterface

// File: rtl/enemy_wave_controller.sv
// Enemy formation sequencer: spawn delay, side-to-side march with descents,
// per-slot kills, wave clear with speed-up, and game over at the bottom limit.
//
// state      | meaning
// IDLE       | no game running, formation hidden
// SPAWN_WAIT | counting frames before the next wave appears
// MARCH      | formation steps horizontally once per frame
// DESCEND    | edge was hit; drop one row on the next frame
// CLEARED    | one-clock wave-complete pulse, speed-up applied
// GAME_OVER  | formation reached the bottom; frozen until startGame
module enemy_wave_controller #(
   parameter int INITIAL_X          = 240,
   parameter int INITIAL_Y          = 32,
   parameter int FORMATION_WIDTH_X  = 240,
   parameter int FORMATION_HEIGHT_Y = 60,
   parameter int X_SPEED            = 80,
   parameter int SPEED_STEP         = 16,
   parameter int MAX_SPEED          = 256,
   parameter int DESCEND_Y          = 16,
   parameter int BOTTOM_LIMIT       = 400,
   parameter int SPAWN_DELAY_FRAMES = 60
) (
   input logic         clk,
   input logic         resetN,
   enemy_wave_if.slave ewif
);

   localparam int POS_W   = 20;
   localparam int X_LIMIT = (640 - FORMATION_WIDTH_X) * 64;

   typedef enum logic [2:0] {
      IDLE, SPAWN_WAIT, MARCH, DESCEND, CLEARED, GAME_OVER
   } state_t;

   state_t                    state_q, state_d;
   logic signed [POS_W-1:0]   pos_x_q, pos_x_d;
   logic signed [POS_W-1:0]   pos_y_q, pos_y_d;
   logic                      dir_left_q, dir_left_d;
   logic [15:0]               speed_q, speed_d;
   logic [15:0]               cnt_q, cnt_d;
   logic [7:0]                alive_q, alive_d;
   logic [3:0]                wave_q, wave_d;
   logic [10:0]               form_x_q, form_y_q;
   logic                      wave_cleared_q, reached_bottom_q;

   logic signed [31:0]        step;
   logic signed [31:0]        next_x;
   logic signed [POS_W-1:0]   new_y;
   logic signed [10:0]        new_top;
   logic                      bottom_hit;
   logic [16:0]               speed_sum;
   logic [15:0]               speed_sat;
   logic [15:0]               cnt_inc;
   logic [7:0]                hit_mask;

   // Fixed point to pixels, truncating toward zero for negative values.
   function automatic logic signed [10:0] to_px(input logic signed [POS_W-1:0] v);
      logic signed [POS_W-1:0] adj;
      adj = v[POS_W-1] ? v + POS_W'(63) : v;
      return 11'(adj >>> 6);
   endfunction

   always_comb begin
      state_d    = state_q;
      pos_x_d    = pos_x_q;
      pos_y_d    = pos_y_q;
      dir_left_d = dir_left_q;
      speed_d    = speed_q;
      cnt_d      = cnt_q;
      alive_d    = alive_q;
      wave_d     = wave_q;

      step       = dir_left_q ? -$signed({16'd0, speed_q}) : $signed({16'd0, speed_q});
      next_x     = $signed({{(32-POS_W){pos_x_q[POS_W-1]}}, pos_x_q}) + step;
      new_y      = pos_y_q + POS_W'(DESCEND_Y * 64);
      new_top    = to_px(new_y);
      bottom_hit = (int'(new_top) + FORMATION_HEIGHT_Y) >= BOTTOM_LIMIT;
      speed_sum  = {1'b0, speed_q} + 17'(SPEED_STEP);
      speed_sat  = (speed_sum > 17'(MAX_SPEED)) ? 16'(MAX_SPEED) : speed_sum[15:0];
      cnt_inc    = cnt_q + 16'd1;
      hit_mask   = alive_q;
      if (ewif.hitValid) hit_mask[ewif.hitIndex] = 1'b0;

      unique case (state_q)
         IDLE: begin
            alive_d = '0;
            if (ewif.startGame) begin
               state_d = SPAWN_WAIT;
               wave_d  = 4'd1;
               speed_d = 16'(X_SPEED);
               cnt_d   = '0;
            end
         end
         SPAWN_WAIT: begin
            if (ewif.startOfFrame) begin
               cnt_d = cnt_inc;
               if (cnt_inc == 16'(SPAWN_DELAY_FRAMES)) begin
                  alive_d    = 8'hFF;
                  pos_x_d    = POS_W'(INITIAL_X * 64);
                  pos_y_d    = POS_W'(INITIAL_Y * 64);
                  dir_left_d = 1'b0;
                  state_d    = MARCH;
               end
            end
         end
         MARCH, DESCEND: begin
            alive_d = hit_mask;
            // An empty formation ends the wave unless this same frame lands it on the bottom.
            if (alive_q == 8'h00) begin
               if (state_q == DESCEND && ewif.startOfFrame && bottom_hit) begin
                  pos_y_d = new_y;
                  state_d = GAME_OVER;
               end else begin
                  state_d = CLEARED;
               end
            end else if (ewif.startOfFrame) begin
               if (state_q == MARCH) begin
                  if (next_x < 0 || next_x > X_LIMIT) begin
                     dir_left_d = ~dir_left_q;
                     state_d    = DESCEND;
                  end else begin
                     pos_x_d = next_x[POS_W-1:0];
                  end
               end else begin
                  pos_y_d = new_y;
                  state_d = bottom_hit ? GAME_OVER : MARCH;
               end
            end
         end
         CLEARED: begin
            wave_d  = wave_q + 4'd1;
            speed_d = speed_sat;
            cnt_d   = '0;
            state_d = SPAWN_WAIT;
         end
         GAME_OVER: begin
            if (ewif.startGame) begin
               state_d = SPAWN_WAIT;
               wave_d  = 4'd1;
               speed_d = 16'(X_SPEED);
               cnt_d   = '0;
               alive_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q          <= IDLE;
         pos_x_q          <= POS_W'(INITIAL_X * 64);
         pos_y_q          <= POS_W'(INITIAL_Y * 64);
         dir_left_q       <= 1'b0;
         speed_q          <= 16'(X_SPEED);
         cnt_q            <= '0;
         alive_q          <= '0;
         wave_q           <= '0;
         form_x_q         <= 11'(INITIAL_X);
         form_y_q         <= 11'(INITIAL_Y);
         wave_cleared_q   <= 1'b0;
         reached_bottom_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         pos_x_q          <= pos_x_d;
         pos_y_q          <= pos_y_d;
         dir_left_q       <= dir_left_d;
         speed_q          <= speed_d;
         cnt_q            <= cnt_d;
         alive_q          <= alive_d;
         wave_q           <= wave_d;
         form_x_q         <= to_px(pos_x_d);
         form_y_q         <= to_px(pos_y_d);
         wave_cleared_q   <= (state_d == CLEARED);
         reached_bottom_q <= (state_d == GAME_OVER);
      end
   end

   assign ewif.formationX    = form_x_q;
   assign ewif.formationY    = form_y_q;
   assign ewif.aliveMask     = alive_q;
   assign ewif.waveNumber    = wave_q;
   assign ewif.waveCleared   = wave_cleared_q;
   assign ewif.reachedBottom = reached_bottom_q;

endmodule

// File: tb/tb_enemy_wave_controller.sv
// Bench for enemy_wave_controller: directed scenario tasks with constant
// expectations, then a randomized run against a frame-level reference model.
module tb_enemy_wave_controller;
   logic clk = 1'b0;
   logic resetN;
   int   checks = 0;
   int   failures = 0;

   enemy_wave_if ewif();

   enemy_wave_controller dut (
      .clk    (clk),
      .resetN (resetN),
      .ewif   (ewif)
   );

   always #5 clk = ~clk;

   // Reference model state (pixel positions kept in 1/64 pixel as plain ints)
   localparam int P_IDLE = 0, P_SPAWN = 1, P_MARCH = 2, P_DESC = 3, P_CLEAR = 4, P_OVER = 5;
   int       m_phase, m_x, m_y, m_dir, m_speed, m_cnt, m_wave;
   bit [7:0] m_mask;
   bit       m_cleared, m_bottom;

   task automatic tick(input logic sof, input logic start, input logic hv, input logic [2:0] hi);
      ewif.startOfFrame = sof;
      ewif.startGame    = start;
      ewif.hitValid     = hv;
      ewif.hitIndex     = hi;
      @(posedge clk);
      #1;
      ewif.startOfFrame = 1'b0;
      ewif.startGame    = 1'b0;
      ewif.hitValid     = 1'b0;
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         tick(1'b1, 1'b0, 1'b0, 3'd0);
         tick(1'b0, 1'b0, 1'b0, 3'd0);
      end
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      tick(1'b0, 1'b0, 1'b0, 3'd0);
      resetN = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (ewif.aliveMask !== 8'h00) begin failures++; $display("FAIL reset_mask got=%h exp=00", ewif.aliveMask); end
      checks++; if (ewif.formationX !== 11'd240) begin failures++; $display("FAIL reset_x got=%0d exp=240", ewif.formationX); end
      checks++; if (ewif.formationY !== 11'd32) begin failures++; $display("FAIL reset_y got=%0d exp=32", ewif.formationY); end
      checks++; if (ewif.waveNumber !== 4'd0) begin failures++; $display("FAIL reset_wave got=%0d exp=0", ewif.waveNumber); end
      checks++; if (ewif.waveCleared !== 1'b0 || ewif.reachedBottom !== 1'b0) begin
         failures++; $display("FAIL reset_flags got=%b%b exp=00", ewif.waveCleared, ewif.reachedBottom); end
   endtask

   task automatic test_spawn();
      tick(1'b0, 1'b1, 1'b0, 3'd0);
      checks++; if (ewif.waveNumber !== 4'd1) begin failures++; $display("FAIL start_wave got=%0d exp=1", ewif.waveNumber); end
      frames(59);
      checks++; if (ewif.aliveMask !== 8'h00) begin failures++; $display("FAIL spawn_early got=%h exp=00", ewif.aliveMask); end
      frames(1);
      checks++; if (ewif.aliveMask !== 8'hFF) begin failures++; $display("FAIL spawn_mask got=%h exp=ff", ewif.aliveMask); end
      checks++; if (ewif.formationX !== 11'd240 || ewif.formationY !== 11'd32) begin
         failures++; $display("FAIL spawn_pos got=%0d,%0d exp=240,32", ewif.formationX, ewif.formationY); end
   endtask

   task automatic test_march();
      frames(1);
      checks++; if (ewif.formationX !== 11'd241) begin failures++; $display("FAIL march_first got=%0d exp=241", ewif.formationX); end
      frames(127);
      checks++; if (ewif.formationX !== 11'd400) begin failures++; $display("FAIL march_edge got=%0d exp=400", ewif.formationX); end
      frames(1);
      checks++; if (ewif.formationX !== 11'd400 || ewif.formationY !== 11'd32) begin
         failures++; $display("FAIL march_bounce got=%0d,%0d exp=400,32", ewif.formationX, ewif.formationY); end
      frames(1);
      checks++; if (ewif.formationY !== 11'd48 || ewif.formationX !== 11'd400) begin
         failures++; $display("FAIL descend got=%0d,%0d exp=400,48", ewif.formationX, ewif.formationY); end
      frames(1);
      checks++; if (ewif.formationX !== 11'd398) begin failures++; $display("FAIL march_left got=%0d exp=398", ewif.formationX); end
   endtask

   task automatic test_hit_with_frame();
      tick(1'b1, 1'b0, 1'b1, 3'd5);
      checks++; if (ewif.aliveMask !== 8'hDF) begin failures++; $display("FAIL hit_frame_mask got=%h exp=df", ewif.aliveMask); end
      checks++; if (ewif.formationX !== 11'd397) begin failures++; $display("FAIL hit_frame_x got=%0d exp=397", ewif.formationX); end
   endtask

   task automatic test_clear();
      int slots[9] = '{0, 1, 2, 3, 3, 4, 5, 6, 7};
      int pulses = 0;
      tick(1'b0, 1'b1, 1'b0, 3'd0);
      checks++; if (ewif.waveNumber !== 4'd1) begin failures++; $display("FAIL start_ignored got=%0d exp=1", ewif.waveNumber); end
      for (int i = 0; i < 9; i++) begin
         tick(1'b0, 1'b0, 1'b1, 3'(slots[i]));
         if (ewif.waveCleared) pulses++;
         if (i == 1) begin
            checks++; if (ewif.aliveMask !== 8'hDC) begin failures++; $display("FAIL partial_mask got=%h exp=dc", ewif.aliveMask); end
         end
      end
      repeat (5) begin
         tick(1'b0, 1'b0, 1'b0, 3'd0);
         if (ewif.waveCleared) pulses++;
      end
      checks++; if (pulses != 1) begin failures++; $display("FAIL clear_pulses got=%0d exp=1", pulses); end
      checks++; if (ewif.waveNumber !== 4'd2) begin failures++; $display("FAIL clear_wave got=%0d exp=2", ewif.waveNumber); end
      tick(1'b0, 1'b0, 1'b1, 3'd4);
      checks++; if (ewif.aliveMask !== 8'h00) begin failures++; $display("FAIL clear_mask got=%h exp=00", ewif.aliveMask); end
      frames(59);
      checks++; if (ewif.aliveMask !== 8'h00) begin failures++; $display("FAIL respawn_early got=%h exp=00", ewif.aliveMask); end
      frames(1);
      checks++; if (ewif.aliveMask !== 8'hFF || ewif.formationX !== 11'd240) begin
         failures++; $display("FAIL respawn got=%h,%0d exp=ff,240", ewif.aliveMask, ewif.formationX); end
      frames(2);
      checks++; if (ewif.formationX !== 11'd243) begin failures++; $display("FAIL speed_up got=%0d exp=243", ewif.formationX); end
   endtask

   task automatic test_reset_mid_march();
      resetN = 1'b0;
      tick(1'b1, 1'b0, 1'b1, 3'd2);
      resetN = 1'b1;
      checks++; if (ewif.aliveMask !== 8'h00 || ewif.waveNumber !== 4'd0) begin
         failures++; $display("FAIL midreset_state got=%h,%0d exp=00,0", ewif.aliveMask, ewif.waveNumber); end
      checks++; if (ewif.formationX !== 11'd240 || ewif.formationY !== 11'd32) begin
         failures++; $display("FAIL midreset_pos got=%0d,%0d exp=240,32", ewif.formationX, ewif.formationY); end
   endtask

   task automatic test_game_over();
      int n = 0;
      int prev_y = 0;
      logic [10:0] x_frozen;
      do_reset();
      tick(1'b0, 1'b1, 1'b0, 3'd0);
      frames(60);
      while (ewif.reachedBottom !== 1'b1 && n < 8000) begin
         prev_y = int'(ewif.formationY);
         frames(1);
         n++;
      end
      checks++; if (ewif.reachedBottom !== 1'b1) begin
         failures++; $display("FAIL gameover_timeout got=%b exp=1", ewif.reachedBottom);
      end else begin
         checks++; if (ewif.formationY !== 11'd352 || prev_y != 336) begin
            failures++; $display("FAIL gameover_y got=%0d(prev %0d) exp=352(prev 336)", ewif.formationY, prev_y); end
         x_frozen = ewif.formationX;
         frames(3);
         tick(1'b0, 1'b0, 1'b1, 3'd1);
         checks++; if (ewif.formationX !== x_frozen || ewif.formationY !== 11'd352 || ewif.aliveMask !== 8'hFF) begin
            failures++; $display("FAIL gameover_frozen got=%0d,%0d,%h exp=%0d,352,ff",
                                 ewif.formationX, ewif.formationY, ewif.aliveMask, x_frozen); end
         tick(1'b0, 1'b1, 1'b0, 3'd0);
         checks++; if (ewif.reachedBottom !== 1'b0 || ewif.waveNumber !== 4'd1) begin
            failures++; $display("FAIL restart got=%b,%0d exp=0,1", ewif.reachedBottom, ewif.waveNumber); end
         frames(60);
         checks++; if (ewif.aliveMask !== 8'hFF || ewif.formationY !== 11'd32) begin
            failures++; $display("FAIL restart_spawn got=%h,%0d exp=ff,32", ewif.aliveMask, ewif.formationY); end
      end
   endtask

   task automatic model_reset();
      m_phase = P_IDLE; m_x = 240 * 64; m_y = 32 * 64; m_dir = 1; m_speed = 80;
      m_cnt = 0; m_wave = 0; m_mask = 8'h00; m_cleared = 1'b0; m_bottom = 1'b0;
   endtask

   task automatic model_begin();
      m_phase = P_SPAWN; m_wave = 1; m_speed = 80; m_cnt = 0; m_mask = 8'h00;
   endtask

   task automatic model_step(input bit rst_n, input bit sof, input bit start, input bit hv, input int hi);
      bit was_empty;
      int nx;
      if (!rst_n) begin
         model_reset();
         return;
      end
      case (m_phase)
         P_IDLE: begin
            m_mask = 8'h00;
            if (start) model_begin();
         end
         P_SPAWN: if (sof) begin
            m_cnt++;
            if (m_cnt == 60) begin
               m_mask = 8'hFF; m_x = 240 * 64; m_y = 32 * 64; m_dir = 1; m_phase = P_MARCH;
            end
         end
         P_MARCH, P_DESC: begin
            was_empty = (m_mask == 8'h00);
            if (hv) m_mask[hi] = 1'b0;
            if (was_empty) begin
               if (m_phase == P_DESC && sof && ((m_y + 1024) / 64 + 60 >= 400)) begin
                  m_y += 1024; m_phase = P_OVER;
               end else begin
                  m_phase = P_CLEAR;
               end
            end else if (sof) begin
               if (m_phase == P_MARCH) begin
                  nx = m_x + m_dir * m_speed;
                  if (nx < 0 || nx > 400 * 64) begin m_dir = -m_dir; m_phase = P_DESC; end
                  else m_x = nx;
               end else begin
                  m_y += 1024;
                  m_phase = (m_y / 64 + 60 >= 400) ? P_OVER : P_MARCH;
               end
            end
         end
         P_CLEAR: begin
            m_wave = (m_wave + 1) % 16;
            m_speed = (m_speed + 16 > 256) ? 256 : m_speed + 16;
            m_cnt = 0;
            m_phase = P_SPAWN;
         end
         P_OVER: if (start) model_begin();
         default: m_phase = P_IDLE;
      endcase
      m_cleared = (m_phase == P_CLEAR);
      m_bottom  = (m_phase == P_OVER);
   endtask

   task automatic test_random();
      bit r, s, st, hv;
      int hi;
      logic [35:0] got, exp;
      do_reset();
      model_reset();
      for (int i = 0; i < 6000; i++) begin
         r  = ($urandom_range(0, 1999) != 0);
         s  = ($urandom_range(0, 2) == 0);
         st = (i == 0) || ($urandom_range(0, 99) == 0);
         hv = ($urandom_range(0, 5) == 0);
         hi = int'($urandom_range(0, 7));
         resetN = r;
         tick(s, st, hv, 3'(hi));
         model_step(r, s, st, hv, hi);
         exp = {11'(m_x / 64), 11'(m_y / 64), m_mask, 4'(m_wave), m_cleared, m_bottom};
         got = {ewif.formationX, ewif.formationY, ewif.aliveMask, ewif.waveNumber,
                ewif.waveCleared, ewif.reachedBottom};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL random cycle=%0d got x=%0d y=%0d m=%h w=%0d c=%b b=%b exp x=%0d y=%0d m=%h w=%0d c=%b b=%b",
                     i, got[35:25], got[24:14], got[13:6], got[5:2], got[1], got[0],
                     exp[35:25], exp[24:14], exp[13:6], exp[5:2], exp[1], exp[0]);
         end
      end
      resetN = 1'b1;
   endtask

   initial begin
      resetN            = 1'b0;
      ewif.startOfFrame = 1'b0;
      ewif.startGame    = 1'b0;
      ewif.hitValid     = 1'b0;
      ewif.hitIndex     = 3'd0;
      test_reset();
      test_spawn();
      test_march();
      test_hit_with_frame();
      test_clear();
      test_reset_mid_march();
      test_game_over();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
